// File: rtl/scan_display_4dig.sv
// Four-digit multiplexed common-anode 7-segment driver for the ALU result bus.
// Snapshots the value once per frame and scans digits 0..3 with hex glyphs.
module scan_display_4dig #(
  parameter int CLK_DIV    = 50000,
  parameter bit LEAD_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num,
  input  logic [3:0]  blank,
  output logic [0:6]  sevenseg,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   num_q, num_d;
  logic [3:0]    anode_q, anode_d;
  logic [0:6]    sevenseg_q, sevenseg_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tick;
  logic          frame_load;
  logic [3:0]    nibble;
  logic          auto_blank;
  logic          dark;
  logic [0:6]    glyph;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      digit_q      <= 2'd3;
      num_q        <= '0;
      anode_q      <= 4'b1111;
      sevenseg_q   <= 7'b1111111;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      num_q        <= num_d;
      anode_q      <= anode_d;
      sevenseg_q   <= sevenseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    tick         = (presc_q == PRESC_MAX);
    presc_d      = tick ? '0 : presc_q + PW'(1);
    digit_d      = tick ? digit_q + 2'd1 : digit_q;
    frame_load   = tick && (digit_q == 2'd3);
    num_d        = frame_load ? num : num_q;
    frame_tick_d = frame_load;
  end

  // Digit k is a leading zero only if every nibble from k upward is zero.
  always_comb begin
    nibble     = num_q[3:0];
    auto_blank = 1'b0;
    case (digit_q)
      2'd0: nibble = num_q[3:0];
      2'd1: begin
        nibble     = num_q[7:4];
        auto_blank = (num_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble     = num_q[11:8];
        auto_blank = (num_q[15:8] == 8'h00);
      end
      2'd3: begin
        nibble     = num_q[15:12];
        auto_blank = (num_q[15:12] == 4'h0);
      end
      default: begin
        nibble     = num_q[3:0];
        auto_blank = 1'b0;
      end
    endcase
    dark = blank[digit_q] | (LEAD_BLANK & auto_blank);
  end

  always_comb begin
    glyph = 7'b1111111;
    case (nibble)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
      default: glyph = 7'b1111111;
    endcase
  end

  always_comb begin
    anode_d    = dark ? 4'b1111 : ~(4'b0001 << digit_q);
    sevenseg_d = dark ? 7'b1111111 : glyph;
  end

  assign anode      = anode_q;
  assign sevenseg   = sevenseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/scan_display_4dig.md
Name: scan_display_4dig

Overview:
- Downstream consumer of the ALU result bus: takes the 16-bit, 4-nibble value the ALU output multiplexer produces and drives a 4-digit multiplexed common-anode 7-segment display.
- Snapshots the value once per frame so the display never tears mid-scan.
- Time-multiplexes the anodes and decodes each nibble to hex glyphs 0-F.
- Supports per-digit forced blanking and optional leading-zero blanking.

Parameters:
- CLK_DIV, 50000: clocks per digit slot. At 100 MHz this gives 2 kHz per digit and a 500 Hz frame. Must be >= 2.
- LEAD_BLANK, 0: when 1, leading zero digits are blanked automatically.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous reset, active-low
- num  in  16  value to show; num[3:0] goes to the rightmost digit (digit 0), num[15:12] to digit 3
- blank  in  4  blank[k]=1 forces digit k dark
- sevenseg  out  [0:6]  segments a..g, sevenseg[0]=a, active-low; registered
- anode  out  4  active-low one-hot digit select, anode[k] drives digit k; registered
- frame_tick  out  1  one-cycle pulse marking a snapshot load

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler=0, digit=3, num_q=0
  - anode=4'b1111, sevenseg=7'b1111111, frame_tick=0
  - Reset takes effect mid-scan too: outputs go dark immediately.
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps to 0
  - tick is asserted combinationally while prescaler==CLK_DIV-1
- Digit index: 2-bit, advances on each tick edge, wrapping 3->0.
  - Reset value 3, so the first tick after reset is a frame boundary.
- Snapshot: on the tick edge where digit goes 3->0:
  - num_q<=num
  - frame_tick<=1 for exactly one cycle
  - On every other edge frame_tick<=0.
  - Changes on num between frame boundaries are not visible until the next boundary.
- Output register: every clock, anode and sevenseg are loaded from the current digit and num_q. They therefore trail a digit change by one clock, and both always update on the same edge.
  - anode = ~(4'b0001<<digit)
  - sevenseg = decode(num_q[4*digit+3 : 4*digit])
- Blanking: the active digit is dark (anode=4'b1111, sevenseg=7'b1111111) if either condition holds:
  - blank[digit]=1
  - LEAD_BLANK=1 and auto-blank applies
- Auto-blank rules (LEAD_BLANK=1):
  - digit 3 when nib3==0
  - digit 2 when nib3==0 and nib2==0
  - digit 1 when nib3, nib2 and nib1 are all 0
  - digit 0 is never auto-blanked
- Decode, value -> a..g, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Timing per frame: 4*CLK_DIV clocks. Each digit is lit for exactly CLK_DIV consecutive clocks.
- No other state: the block never stalls and has no handshake on num.

Test Plan (CLK_DIV=4 unless stated):
1. Hold rst=0, then release with num=16'h1234.
   - Before the release: anode=1111 and sevenseg=1111111.
   - frame_tick pulses on the 4th edge after release.
   - On the next edge: anode=1110, sevenseg=1001100 ("4").
   - Every 4 clocks after that: anode=1101/"3"(0000110), then 1011/"2"(0010010), then 0111/"1"(1001111), then back to 1110.
2. Tearing: after snapshot 16'h1234, set num=16'hABCD during digit 1.
   - Digits 2 and 3 still show "2" and "1".
   - After the next frame_tick: 1110/"d"(1000010), 1101/"C"(0110001), 1011/"b"(1100000), 0111/"A"(0001000).
3. Set blank=4'b0100 with num=16'h8888.
   - Digit 2 slot shows anode=1111 and sevenseg=1111111.
   - Other slots show "8"(0000000) with the correct anode.
4. LEAD_BLANK=1, num=16'h0005: digits 3, 2 and 1 are dark and digit 0 shows "5"(0100100).
   - num=16'h0000: only digit 0 is lit, showing "0".
   - num=16'h0100: digits 1 and 0 show "0", digit 2 shows "1".
5. Assert rst=0 asynchronously mid-slot on digit 2.
   - Outputs go dark immediately, without waiting for a clock edge.
   - After release, the scan restarts at 4 clocks to frame_tick with a fresh snapshot.
6. CLK_DIV=50000 smoke test: measure 200000 clocks between successive frame_tick pulses and 50000 clocks per anode slot.
